// File: rtl/v_rf_banked_if.sv
// Request/response bundle for the banked vector register file.
interface v_rf_banked_if #(
  parameter int unsigned num_regs_p = 8,
  parameter int unsigned vlen_p     = 8,
  parameter int unsigned vdw_p      = 32,
  parameter int unsigned lanes_p    = 4
);
  localparam int unsigned reg_width_lp  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;
  localparam int unsigned addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;

  logic [lanes_p-1:0]               r_v_i;
  logic [lanes_p*reg_width_lp-1:0]  r_reg_i;
  logic [lanes_p*addr_width_lp-1:0] r_addr_i;
  logic [lanes_p-1:0]               r_ready_o;
  logic [lanes_p-1:0]               r_v_o;
  logic [lanes_p*vdw_p-1:0]         r_data_o;
  logic [lanes_p-1:0]               w_v_i;
  logic [lanes_p*reg_width_lp-1:0]  w_reg_i;
  logic [lanes_p*addr_width_lp-1:0] w_addr_i;
  logic [lanes_p*vdw_p-1:0]         w_data_i;
  logic [lanes_p-1:0]               w_ready_o;
  logic                             clr_v_i;
  logic [reg_width_lp-1:0]          clr_reg_i;

  modport master (
    output r_v_i, r_reg_i, r_addr_i, w_v_i, w_reg_i, w_addr_i, w_data_i, clr_v_i, clr_reg_i,
    input  r_ready_o, r_v_o, r_data_o, w_ready_o
  );

  modport slave (
    input  r_v_i, r_reg_i, r_addr_i, w_v_i, w_reg_i, w_addr_i, w_data_i, clr_v_i, clr_reg_i,
    output r_ready_o, r_v_o, r_data_o, w_ready_o
  );
endinterface

// File: rtl/v_rf_banked.sv
// Banked multi-register vector register file: per-bank round-robin 1R1W arbitration,
// 1-cycle registered reads, write-to-read bypass, per-element written flags, register clear.
module v_rf_banked #(
  parameter int unsigned num_regs_p = 8,
  parameter int unsigned vlen_p     = 8,
  parameter int unsigned vdw_p      = 32,
  parameter int unsigned lanes_p    = 4
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  v_rf_banked_if.slave   bus
);
  localparam int unsigned reg_width_lp  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;
  localparam int unsigned addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;
  localparam int unsigned lane_w_lp     = (lanes_p > 1) ? $clog2(lanes_p) : 1;
  localparam int unsigned rpr_lp        = vlen_p / lanes_p;
  localparam int unsigned rows_lp       = num_regs_p * rpr_lp;
  localparam int unsigned row_w_lp      = (rows_lp > 1) ? $clog2(rows_lp) : 1;
  localparam int unsigned elems_lp      = num_regs_p * vlen_p;
  localparam int unsigned elem_w_lp     = (elems_lp > 1) ? $clog2(elems_lp) : 1;

  typedef logic [reg_width_lp-1:0]  reg_t;
  typedef logic [addr_width_lp-1:0] addr_t;
  typedef logic [lane_w_lp-1:0]     lane_t;
  typedef logic [row_w_lp-1:0]      row_t;
  typedef logic [elem_w_lp-1:0]     elem_t;
  typedef logic [vdw_p-1:0]         data_t;

  function automatic lane_t bank_of(input addr_t a);
    return lane_t'(32'(a) % lanes_p);
  endfunction

  function automatic row_t row_of(input reg_t r, input addr_t a);
    return row_t'(32'(r) * rpr_lp + 32'(a) / lanes_p);
  endfunction

  function automatic elem_t elem_of(input reg_t r, input addr_t a);
    return elem_t'(32'(r) * vlen_p + 32'(a));
  endfunction

  function automatic lane_t rr_idx(input lane_t p, input int unsigned k);
    return lane_t'((32'(p) + k) % lanes_p);
  endfunction

  reg_t  r_reg  [lanes_p];
  addr_t r_addr [lanes_p];
  reg_t  w_reg  [lanes_p];
  addr_t w_addr [lanes_p];
  data_t w_data [lanes_p];

  lane_t r_ptr_q [lanes_p];
  lane_t w_ptr_q [lanes_p];
  lane_t r_win   [lanes_p];
  lane_t w_win   [lanes_p];
  logic [lanes_p-1:0] r_any, w_any, r_gnt, w_gnt;

  logic [elems_lp-1:0] flags_q;
  data_t mem_q [lanes_p][rows_lp];

  lane_t rd_bank   [lanes_p];
  lane_t rd_wlane  [lanes_p];
  data_t rd_data_c [lanes_p];

  // Unpack the flat lane buses.
  always_comb begin
    for (int l = 0; l < lanes_p; l++) begin
      r_reg[l]  = bus.r_reg_i[l*reg_width_lp +: reg_width_lp];
      r_addr[l] = bus.r_addr_i[l*addr_width_lp +: addr_width_lp];
      w_reg[l]  = bus.w_reg_i[l*reg_width_lp +: reg_width_lp];
      w_addr[l] = bus.w_addr_i[l*addr_width_lp +: addr_width_lp];
      w_data[l] = bus.w_data_i[l*vdw_p +: vdw_p];
    end
  end

  // Per-bank round-robin: first requesting lane at or after the pointer wins.
  always_comb begin
    r_any = '0;
    w_any = '0;
    r_gnt = '0;
    w_gnt = '0;
    for (int b = 0; b < lanes_p; b++) begin
      r_win[b] = '0;
      w_win[b] = '0;
    end
    for (int b = 0; b < lanes_p; b++) begin
      for (int unsigned k = 0; k < lanes_p; k++) begin
        if (!r_any[b] && bus.r_v_i[rr_idx(r_ptr_q[b], k)] &&
            bank_of(r_addr[rr_idx(r_ptr_q[b], k)]) == lane_t'(b)) begin
          r_any[b] = 1'b1;
          r_win[b] = rr_idx(r_ptr_q[b], k);
        end
        if (!w_any[b] && bus.w_v_i[rr_idx(w_ptr_q[b], k)] &&
            bank_of(w_addr[rr_idx(w_ptr_q[b], k)]) == lane_t'(b)) begin
          w_any[b] = 1'b1;
          w_win[b] = rr_idx(w_ptr_q[b], k);
        end
      end
      if (r_any[b]) r_gnt[r_win[b]] = 1'b1;
      if (w_any[b]) w_gnt[w_win[b]] = 1'b1;
    end
  end

  assign bus.r_ready_o = r_gnt;
  assign bus.w_ready_o = w_gnt;

  // Read data: same-cycle write to the same element wins, unwritten elements read as zero.
  always_comb begin
    for (int l = 0; l < lanes_p; l++) begin
      rd_bank[l]  = bank_of(r_addr[l]);
      rd_wlane[l] = w_win[rd_bank[l]];
      if (w_any[rd_bank[l]] && w_reg[rd_wlane[l]] == r_reg[l] && w_addr[rd_wlane[l]] == r_addr[l])
        rd_data_c[l] = w_data[rd_wlane[l]];
      else if (flags_q[elem_of(r_reg[l], r_addr[l])])
        rd_data_c[l] = mem_q[rd_bank[l]][row_of(r_reg[l], r_addr[l])];
      else
        rd_data_c[l] = '0;
    end
  end

  // Storage is left unreset; it is only ever written outside reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < lanes_p; b++) begin
        r_ptr_q[b] <= '0;
        w_ptr_q[b] <= '0;
      end
      flags_q      <= '0;
      bus.r_v_o    <= '0;
      bus.r_data_o <= '0;
    end else begin
      for (int b = 0; b < lanes_p; b++) begin
        if (r_any[b]) r_ptr_q[b] <= rr_idx(r_win[b], 1);
        if (w_any[b]) w_ptr_q[b] <= rr_idx(w_win[b], 1);
      end
      if (bus.clr_v_i) begin
        for (int unsigned e = 0; e < vlen_p; e++)
          flags_q[elem_of(bus.clr_reg_i, addr_t'(e))] <= 1'b0;
      end
      for (int b = 0; b < lanes_p; b++) begin
        if (w_any[b]) begin
          flags_q[elem_of(w_reg[w_win[b]], w_addr[w_win[b]])] <= 1'b1;
          mem_q[b][row_of(w_reg[w_win[b]], w_addr[w_win[b]])] <= w_data[w_win[b]];
        end
      end
      bus.r_v_o <= r_gnt;
      for (int l = 0; l < lanes_p; l++) begin
        if (r_gnt[l]) bus.r_data_o[l*vdw_p +: vdw_p] <= rd_data_c[l];
      end
    end
  end
endmodule

// File: tb/tb_v_rf_banked.sv
// Directed table-driven bench for v_rf_banked (4 lanes, 8 regs x 8 elements x 32 bits).
module tb_v_rf_banked;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  v_rf_banked_if #(.num_regs_p(8), .vlen_p(8), .vdw_p(32), .lanes_p(4)) bus ();

  v_rf_banked #(.num_regs_p(8), .vlen_p(8), .vdw_p(32), .lanes_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // One cycle of stimulus plus what must be observed during that cycle.
  typedef struct packed {
    logic [3:0]        r_v;
    logic [3:0][2:0]   r_reg;
    logic [3:0][2:0]   r_addr;
    logic [3:0]        w_v;
    logic [3:0][2:0]   w_reg;
    logic [3:0][2:0]   w_addr;
    logic [3:0][31:0]  w_data;
    logic              clr_v;
    logic [2:0]        clr_reg;
    logic [3:0]        e_rr;
    logic [3:0]        e_wr;
    logic [3:0]        e_rv;
    logic [3:0][31:0]  e_rd;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic rd(input int l, input int r, input int a);
    cur.r_v[l]    = 1'b1;
    cur.r_reg[l]  = 3'(r);
    cur.r_addr[l] = 3'(a);
  endtask

  task automatic wr(input int l, input int r, input int a, input logic [31:0] d);
    cur.w_v[l]    = 1'b1;
    cur.w_reg[l]  = 3'(r);
    cur.w_addr[l] = 3'(a);
    cur.w_data[l] = d;
  endtask

  task automatic er(input int l, input logic [31:0] d);
    cur.e_rv[l] = 1'b1;
    cur.e_rd[l] = d;
  endtask

  task automatic push(input logic [3:0] rr, input logic [3:0] wrr);
    cur.e_rr = rr;
    cur.e_wr = wrr;
    vecs.push_back(cur);
    cur = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.r_v_i     = v.r_v;
    bus.r_reg_i   = v.r_reg;
    bus.r_addr_i  = v.r_addr;
    bus.w_v_i     = v.w_v;
    bus.w_reg_i   = v.w_reg;
    bus.w_addr_i  = v.w_addr;
    bus.w_data_i  = v.w_data;
    bus.clr_v_i   = v.clr_v;
    bus.clr_reg_i = v.clr_reg;
  endtask

  initial begin
    cur = '0;
    drive(cur);

    // Unwritten read.
    rd(0, 3, 5);                                   push(4'b0001, 4'b0000);
    er(0, 32'h0);                                  push(4'b0000, 4'b0000);
    // Write then read, and same-cycle bypass.
    wr(2, 1, 6, 32'hDEADBEEF);                     push(4'b0000, 4'b0100);
    rd(0, 1, 6);                                   push(4'b0001, 4'b0000);
    wr(1, 1, 7, 32'h1234); rd(3, 1, 7);
    er(0, 32'hDEADBEEF);                           push(4'b1000, 4'b0010);
    er(3, 32'h1234);                               push(4'b0000, 4'b0000);
    // Conflicting writes to banks 0/1, losers hold.
    wr(0, 2, 0, 32'h100); wr(1, 2, 4, 32'h104); wr(2, 2, 1, 32'h101); wr(3, 2, 5, 32'h105);
    push(4'b0000, 4'b0101);
    wr(1, 2, 4, 32'h104); wr(3, 2, 5, 32'h105);    push(4'b0000, 4'b1010);
    // All lanes read banks 0,0,1,1 on consecutive cycles.
    rd(0, 2, 0); rd(1, 2, 4); rd(2, 2, 1); rd(3, 2, 5); push(4'b0101, 4'b0000);
    rd(0, 2, 0); rd(1, 2, 4); rd(2, 2, 1); rd(3, 2, 5);
    er(0, 32'h100); er(2, 32'h101);                push(4'b1010, 4'b0000);
    er(1, 32'h104); er(3, 32'h105);                push(4'b0000, 4'b0000);
    // Persistent contention on one bank rotates the grant.
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < 4; l++) wr(l, 6, (l % 2 != 0) ? 5 : 1, 32'h60 + 32'(l));
      push(4'b0000, 4'(1 << (c % 4)));
    end
    rd(0, 6, 5);                                   push(4'b0001, 4'b0000);
    rd(3, 6, 1); er(0, 32'h63);                    push(4'b1000, 4'b0000);
    er(3, 32'h60);                                 push(4'b0000, 4'b0000);
    // Fill reg 4 and reg 5, then clear reg 4 with a same-cycle write and reads.
    for (int l = 0; l < 4; l++) wr(l, 4, l, 32'h40 + 32'(l));     push(4'b0000, 4'b1111);
    for (int l = 0; l < 4; l++) wr(l, 4, l + 4, 32'h44 + 32'(l)); push(4'b0000, 4'b1111);
    for (int l = 0; l < 4; l++) wr(l, 5, l, 32'h50 + 32'(l));     push(4'b0000, 4'b1111);
    cur.clr_v = 1'b1; cur.clr_reg = 3'd4;
    wr(0, 4, 2, 32'hAA); rd(1, 4, 1); rd(2, 4, 2); push(4'b0110, 4'b0001);
    for (int l = 0; l < 4; l++) rd(l, 4, l);
    er(1, 32'h41); er(2, 32'hAA);                  push(4'b1111, 4'b0000);
    for (int l = 0; l < 4; l++) rd(l, 4, l + 4);
    er(0, 0); er(1, 0); er(2, 32'hAA); er(3, 0);   push(4'b1111, 4'b0000);
    for (int l = 0; l < 4; l++) begin rd(l, 5, l); er(l, 0); end
    push(4'b1111, 4'b0000);
    for (int l = 0; l < 4; l++) er(l, 32'h50 + 32'(l));
    push(4'b0000, 4'b0000);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset r_v_o", 128'(bus.r_v_o), 128'h0);
    chk("reset r_data_o", 128'(bus.r_data_o), 128'h0);
    chk("reset r_ready_o", 128'(bus.r_ready_o), 128'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d r_ready", i), 128'(bus.r_ready_o), 128'(vecs[i].e_rr));
      chk($sformatf("v%0d w_ready", i), 128'(bus.w_ready_o), 128'(vecs[i].e_wr));
      chk($sformatf("v%0d r_v", i), 128'(bus.r_v_o), 128'(vecs[i].e_rv));
      for (int l = 0; l < 4; l++)
        if (vecs[i].e_rv[l])
          chk($sformatf("v%0d r_data lane%0d", i, l), 128'(bus.r_data_o[l*32 +: 32]),
              128'(vecs[i].e_rd[l]));
    end

    // Read data holds while r_v_o is low.
    cur = '0;
    @(posedge clk);
    #1 drive(cur);
    @(negedge clk);
    chk("hold r_v", 128'(bus.r_v_o), 128'h0);
    chk("hold r_data", 128'(bus.r_data_o), 128'h00000053_00000052_00000051_00000050);

    // Reset asserted mid-cycle with a read in flight.
    @(posedge clk);
    #1 rd(0, 5, 0); drive(cur);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid r_v_o", 128'(bus.r_v_o), 128'h0);
    chk("rst_mid r_data_o", 128'(bus.r_data_o), 128'h0);
    chk("rst_mid ready follows valid", 128'(bus.r_ready_o), 128'h1);
    cur = '0;
    drive(cur);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 rd(0, 5, 0); drive(cur); cur = '0;
    @(posedge clk);
    #1 drive(cur);
    @(negedge clk);
    chk("post_rst r_v", 128'(bus.r_v_o), 128'h1);
    chk("post_rst r_data lane0", 128'(bus.r_data_o[31:0]), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
